// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between icache refills and dcache refill/writeback.
// One transaction in flight; dcache wins ties unless icache has waited too long.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 128,
    parameter int MAX_DC_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ic_req_valid,
    output logic                  ic_req_ready,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    output logic                  ic_resp_valid,
    output logic [DATA_WIDTH-1:0] ic_resp_data,
    input  logic                  dc_req_valid,
    output logic                  dc_req_ready,
    input  logic                  dc_req_rw,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr,
    input  logic [DATA_WIDTH-1:0] dc_req_wdata,
    output logic                  dc_resp_valid,
    output logic [DATA_WIDTH-1:0] dc_resp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_rw,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  busy,
    output logic                  err
);

    localparam int SW = $clog2(MAX_DC_STREAK) + 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DC_STREAK);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         streak_q, streak_d;
    logic                  ic_rv_q, ic_rv_d;
    logic                  dc_rv_q, dc_rv_d;
    logic [DATA_WIDTH-1:0] ic_rd_q, ic_rd_d;
    logic [DATA_WIDTH-1:0] dc_rd_q, dc_rd_d;
    logic                  err_q, err_d;
    logic                  busy_q;
    logic                  ic_gnt, dc_gnt;

    // Grants are combinational so the winner sees ready in the request cycle.
    always_comb begin
        ic_gnt = 1'b0;
        dc_gnt = 1'b0;
        if (!reset && state_q == IDLE) begin
            if (dc_req_valid && !(ic_req_valid && streak_q == STREAK_MAX))
                dc_gnt = 1'b1;
            else if (ic_req_valid)
                ic_gnt = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        streak_d = streak_q;
        ic_rv_d  = 1'b0;
        dc_rv_d  = 1'b0;
        ic_rd_d  = ic_rd_q;
        dc_rd_d  = dc_rd_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (mem_resp_valid)
                    err_d = 1'b1;
                if (dc_gnt) begin
                    owner_d = 1'b1;
                    rw_d    = dc_req_rw;
                    addr_d  = dc_req_addr;
                    wdata_d = dc_req_wdata;
                    state_d = ISSUE;
                    if (!ic_req_valid)
                        streak_d = '0;
                    else if (streak_q != STREAK_MAX)
                        streak_d = streak_q + SW'(1);
                end else if (ic_gnt) begin
                    owner_d  = 1'b0;
                    rw_d     = 1'b0;
                    addr_d   = ic_req_addr;
                    wdata_d  = '0;
                    streak_d = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_resp_valid)
                    err_d = 1'b1;
                if (mem_req_ready)
                    state_d = rw_q ? IDLE : WAIT_RESP;
            end
            WAIT_RESP: begin
                if (mem_resp_valid) begin
                    if (owner_q) begin
                        dc_rv_d = 1'b1;
                        dc_rd_d = mem_resp_data;
                    end else begin
                        ic_rv_d = 1'b1;
                        ic_rd_d = mem_resp_data;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            streak_q <= '0;
            ic_rv_q  <= 1'b0;
            dc_rv_q  <= 1'b0;
            ic_rd_q  <= '0;
            dc_rd_q  <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            streak_q <= streak_d;
            ic_rv_q  <= ic_rv_d;
            dc_rv_q  <= dc_rv_d;
            ic_rd_q  <= ic_rd_d;
            dc_rd_q  <= dc_rd_d;
            err_q    <= err_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    assign ic_req_ready  = ic_gnt;
    assign dc_req_ready  = dc_gnt;
    assign ic_resp_valid = ic_rv_q;
    assign ic_resp_data  = ic_rd_q;
    assign dc_resp_valid = dc_rv_q;
    assign dc_resp_data  = dc_rd_q;
    assign mem_req_valid = (state_q == ISSUE);
    assign mem_req_rw    = rw_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign busy          = busy_q;
    assign err           = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard
// and a one-cycle-latency memory model.
module tb_mem_port_arbiter;

    typedef struct {
        logic         dc;
        logic [127:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         ic_req_valid, ic_req_ready;
    logic [31:0]  ic_req_addr;
    logic         ic_resp_valid;
    logic [127:0] ic_resp_data;
    logic         dc_req_valid, dc_req_ready, dc_req_rw;
    logic [31:0]  dc_req_addr;
    logic [127:0] dc_req_wdata;
    logic         dc_resp_valid;
    logic [127:0] dc_resp_data;
    logic         mem_req_valid, mem_req_ready, mem_req_rw;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_wdata;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic         busy, err;

    logic         model_rv, inject_rv;
    logic [127:0] model_rd;
    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready),
        .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
        .dc_req_wdata(dc_req_wdata),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mem_data(input logic [31:0] a);
        if (a == 32'h100)
            return {16{8'hA5}};
        return {a ^ 32'hC0DE0000, ~a, a, a ^ 32'h12345678};
    endfunction

    // Memory: accepts when ready, returns read data on the following cycle.
    always @(posedge clk) begin
        if (reset) begin
            model_rv <= 1'b0;
            model_rd <= '0;
        end else begin
            model_rv <= mem_req_valid && mem_req_ready && !mem_req_rw;
            model_rd <= mem_data(mem_req_addr);
        end
    end
    assign mem_resp_valid = model_rv | inject_rv;
    assign mem_resp_data  = model_rd;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ic_resp_valid || dc_resp_valid) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_port", {dc_resp_valid, ic_resp_valid},
                    e.dc ? 2'b10 : 2'b01);
                chk("resp_data", e.dc ? dc_resp_data : ic_resp_data, e.data);
            end
        end
    end

    task automatic wait_grant(output logic got_dc);
        for (int i = 0; i < 20; i++) begin
            if (dc_req_ready || ic_req_ready) begin
                got_dc = dc_req_ready;
                chk("ready_onehot", dc_req_ready & ic_req_ready, 1'b0);
                return;
            end
            @(negedge clk); #1;
        end
        got_dc = 1'b0;
        chk("grant_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            if (!busy && sb.size() == 0)
                return;
            @(negedge clk); #1;
        end
        chk("idle_timeout", 1'b0, 1'b1);
    endtask

    task automatic do_ic_read(input logic [31:0] a);
        logic g;
        ic_req_valid = 1'b1;
        ic_req_addr  = a;
        #1;
        wait_grant(g);
        chk("ic_grant_port", g, 1'b0);
        sb.push_back('{1'b0, mem_data(a)});
        @(negedge clk); #1;
        ic_req_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        logic g;
        logic exp_order [10];
        reset         = 1'b1;
        ic_req_valid  = 1'b1;
        ic_req_addr   = 32'h180;
        dc_req_valid  = 1'b1;
        dc_req_rw     = 1'b0;
        dc_req_addr   = 32'h300;
        dc_req_wdata  = '0;
        mem_req_ready = 1'b1;
        inject_rv     = 1'b0;

        // Reset with both requesters asserting
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ic_ready", ic_req_ready, 1'b0);
        chk("rst_dc_ready", dc_req_ready, 1'b0);
        chk("rst_mem_valid", mem_req_valid, 1'b0);
        chk("rst_mem_addr", mem_req_addr, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ic_data", ic_resp_data, 128'h0);
        reset = 1'b0;
        #1;
        chk("first_dc_ready", dc_req_ready, 1'b1);
        chk("first_ic_ready", ic_req_ready, 1'b0);
        sb.push_back('{1'b1, mem_data(32'h300)});
        @(negedge clk); #1;
        dc_req_valid = 1'b0;
        wait_grant(g);
        chk("second_grant_ic", g, 1'b0);
        sb.push_back('{1'b0, mem_data(32'h180)});
        @(negedge clk); #1;
        ic_req_valid = 1'b0;
        wait_idle();

        // Lone icache read at 0x100
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h100;
        #1;
        chk("lone_ic_ready", ic_req_ready, 1'b1);
        sb.push_back('{1'b0, {16{8'hA5}}});
        @(negedge clk); #1;
        ic_req_valid = 1'b0;
        chk("lone_mem_valid", mem_req_valid, 1'b1);
        chk("lone_mem_addr", mem_req_addr, 32'h100);
        chk("lone_mem_rw", mem_req_rw, 1'b0);
        @(negedge clk); #1;
        chk("lone_no_early_resp", ic_resp_valid, 1'b0);
        @(negedge clk); #1;
        chk("lone_resp_valid", ic_resp_valid, 1'b1);
        chk("lone_resp_data", ic_resp_data, {16{8'hA5}});
        chk("lone_dc_quiet", dc_resp_valid, 1'b0);
        chk("lone_idle", busy, 1'b0);
        wait_idle();

        // Starvation guard: four dcache grants, then icache
        exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h200;
        dc_req_valid = 1'b1;
        dc_req_rw    = 1'b0;
        dc_req_addr  = 32'h300;
        #1;
        for (int k = 0; k < 10; k++) begin
            wait_grant(g);
            chk($sformatf("grant_order_%0d", k), g, exp_order[k]);
            sb.push_back('{g, mem_data(g ? 32'h300 : 32'h200)});
            @(negedge clk); #1;
            if (k == 9) begin
                ic_req_valid = 1'b0;
                dc_req_valid = 1'b0;
            end
        end
        wait_idle();

        // dcache write with memory stalled three cycles
        mem_req_ready = 1'b0;
        dc_req_valid  = 1'b1;
        dc_req_rw     = 1'b1;
        dc_req_addr   = 32'h40;
        dc_req_wdata  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        #1;
        chk("wr_ready", dc_req_ready, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            if (k == 0)
                dc_req_valid = 1'b0;
            chk("wr_mem_valid", mem_req_valid, 1'b1);
            chk("wr_mem_rw", mem_req_rw, 1'b1);
            chk("wr_mem_addr", mem_req_addr, 32'h40);
            chk("wr_mem_wdata", mem_req_wdata,
                128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE);
            if (k == 3)
                mem_req_ready = 1'b1;
        end
        @(negedge clk); #1;
        chk("wr_idle_busy", busy, 1'b0);
        chk("wr_idle_mem_valid", mem_req_valid, 1'b0);
        dc_req_rw = 1'b0;
        repeat (3) @(negedge clk);
        #1;

        // Stray memory response while idle
        inject_rv = 1'b1;
        @(negedge clk); #1;
        inject_rv = 1'b0;
        chk("stray_err", err, 1'b1);
        do_ic_read(32'h140);
        chk("err_sticky", err, 1'b1);

        // Reset while waiting for a read response
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h1C0;
        #1;
        chk("rw_grant", ic_req_ready, 1'b1);
        @(negedge clk); #1;
        ic_req_valid = 1'b0;
        @(negedge clk); #1;
        chk("rw_busy_wait", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("rw_busy_after", busy, 1'b0);
        chk("rw_err_cleared", err, 1'b0);
        chk("rw_no_resp", ic_resp_valid, 1'b0);
        chk("rw_mem_valid", mem_req_valid, 1'b0);
        reset = 1'b0;
        ic_req_valid = 1'b1;
        #1;
        chk("post_rst_ready", ic_req_ready, 1'b1);
        sb.push_back('{1'b0, mem_data(32'h1C0)});
        @(negedge clk); #1;
        ic_req_valid = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
